div: RTL and testbench

// - Iterative 32-cycle radix-2 restoring divider for DIV/DIVU. Sits beside EX and feeds it.
// - EX raises start_i and stalls the pipe until ready_o is high.
// - EX then drives result_o onto hi_o/lo_o as {remainder, quotient} with whilo_o=1.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 45 ++++
 rtl/div.sv | 199 +++++++++++++++++++
 tb/tb_div.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider: FSM state codes, handshake
// level names and the EX-stage ALU op codes that route work to the divider.
// No ports; imported by div and div_step.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Divider FSM state codes
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Handshake levels
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // ALU op codes that select the divider in EX
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // True when the ALU op must be sent to the divider
  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring-division iteration.
// Ports:
//   rem_i     [WIDTH-1:0]  partial remainder (always < divisor)
//   quo_i     [WIDTH-1:0]  dividend bits still to shift in / quotient so far
//   divisor_i [WIDTH-1:0]  divisor magnitude
//   rem_o     [WIDTH-1:0]  updated partial remainder
//   quo_o     [WIDTH-1:0]  updated quotient, new bit in LSB
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // Shifted remainder can reach 2*divisor-1, so it needs WIDTH+1 bits;
  // one more bit on the difference gives the borrow.
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] diff_s;
  logic             unused_diff_s;

  // Bit WIDTH of a non-negative difference is always zero (result < divisor)
  assign unused_diff_s = diff_s[WIDTH];

  // Shift in the next dividend bit and try to subtract the divisor
  always_comb begin
    shifted_s = {rem_i, quo_i[WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, divisor_i};
    if (!diff_s[WIDTH+1]) begin
      rem_o = diff_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div
// Iterative WIDTH-cycle radix-2 restoring divider for DIV/DIVU beside EX.
// EX holds start_i high and stalls until ready_o; result_o = {rem, quo}.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous reset, active-low
//   signed_div_i  1 = two's-complement DIV, 0 = DIVU
//   opdata1_i     dividend          opdata2_i  divisor
//   start_i       request, held until the result is consumed
//   annul_i       flush an in-flight division
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//   div_zero_o    divisor was zero (only when DIV_ZERO_FLAG_EN is defined)
// Build option: DIV_ZERO_FLAG_EN adds the div_zero_o flag.
// -----------------------------------------------------------------------------
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               div_zero_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Two's-complement negation at operand width
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   step_rem_s, step_quo_s;
  logic [WIDTH-1:0]   fix_rem_s, fix_quo_s;
`ifdef DIV_ZERO_FLAG_EN
  logic               div_zero_q, div_zero_d;
`endif

  div_step #(
    .WIDTH     (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dsr_q),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // Restore signs: quotient negative when operand signs differ,
  // remainder follows the dividend. 0x80000000/-1 wraps naturally.
  assign fix_quo_s = neg_quo_q ? negate(quo_q) : quo_q;
  assign fix_rem_s = neg_rem_q ? negate(rem_q) : rem_q;

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    div_zero_d = div_zero_q;
`endif
    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if ((start_i == DivStart) && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = (signed_div_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
            dsr_d     = (signed_div_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;
            neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
          end
        end else begin
          state_d = DivFree;
        end
      end
      DivByZero: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d = DivEnd;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = DivEnd;
          cnt_d    = '0;
          result_d = {fix_rem_s, fix_quo_s};
          ready_d  = DivResultReady;
        end else begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DivEnd: begin
        if (annul_i || (start_i == DivStop)) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_d = 1'b0;
`endif
        end else begin
          // The divide-by-zero path arrives here not yet ready; raising
          // ready one cycle later is what marks it as a zero-divisor result.
          ready_d = DivResultReady;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_d = div_zero_q | ~ready_q;
`endif
        end
      end
      default: begin
        state_d  = DivFree;
        cnt_d    = '0;
        result_d = '0;
        ready_d  = DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
        div_zero_d = 1'b0;
`endif
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div
// Directed, table-driven bench for the iterative divider, plus hand-written
// sequences for annul and reset in the middle of a division.
// -----------------------------------------------------------------------------
module tb_div;

  localparam int W      = 32;
  localparam int BUDGET = 60;

  logic          clk;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic          div_zero_o;
`endif

  int n_vec;
  int n_miss;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    int             lat;
    logic           zero;
  } vec_t;

  vec_t vecs[10];

  div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero_o   (div_zero_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts edges from the next one (E0) until ready_o is seen; -1 on timeout
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int e = 0; e <= BUDGET; e++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    signed_div_i = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    start_i      = 1'b1;
    wait_ready(lat);
    check({name, " latency"}, 64'(lat), 64'(v.lat));
    if (lat >= 0) begin
      check({name, " result"}, result_o, v.exp);
`ifdef DIV_ZERO_FLAG_EN
      check({name, " div_zero"}, 64'(div_zero_o), 64'(v.zero));
`endif
      // operands change after acceptance must not matter
      opdata1_i = 32'h1234_5678;
      opdata2_i = 32'h0000_0000;
      @(posedge clk); #1;
      check({name, " held ready"}, 64'(ready_o), 64'd1);
      check({name, " held result"}, result_o, v.exp);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, " drop ready"}, 64'(ready_o), 64'd0);
    check({name, " drop result"}, result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check({name, " drop div_zero"}, 64'(div_zero_o), 64'd0);
`endif
  endtask

  initial begin
    int   lat;
    logic seen;
    vec_t v;

    n_vec  = 0;
    n_miss = 0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        33, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 1'b0};
    vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9, {32'd2,        32'hFFFF_FFF2}, 33, 1'b0};
    vecs[3] = '{1'b0, 32'd5,          32'd0,        {32'd0,        32'd0},         2,  1'b1};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0,        32'h8000_0000}, 33, 1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0,        32'hFFFF_FFFF}, 33, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},       33, 1'b0};
    vecs[7] = '{1'b0, 32'd7,          32'd100,      {32'd7,        32'd0},         33, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFF_FF9C,  32'd7,        {32'd2,        32'h2492_4916}, 33, 1'b0};
    vecs[9] = '{1'b1, 32'd0,          32'd0,        {32'd0,        32'd0},         2,  1'b1};

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset div_zero", 64'(div_zero_o), 64'd0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Annul: 100/7 accepted at E0, annul sampled at E11, then 9/4 from E12
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    seen         = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk); #1;
      seen = seen | ready_o;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    seen = seen | ready_o;
    check("annul no ready", 64'(seen), 64'd0);
    check("annul result", result_o, 64'd0);
    annul_i   = 1'b0;
    opdata1_i = 32'd9;
    opdata2_i = 32'd4;
    wait_ready(lat);
    check("after annul latency", 64'(lat), 64'd33);
    check("after annul result", result_o, {32'd1, 32'd2});
    start_i = 1'b0;
    @(posedge clk); #1;
    check("after annul drop", 64'(ready_o), 64'd0);

    // Reset mid-division: accepted at E0, rst low at E20
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst     = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    check("mid reset ready", 64'(ready_o), 64'd0);
    check("mid reset result", result_o, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    v = '{1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 1'b0};
    run_vec("post reset", v);

    // Reset while a result is being presented
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    wait_ready(lat);
    check("end reset latency", 64'(lat), 64'd33);
    check("end reset pre result", result_o, {32'd0, 32'd10});
    rst = 1'b0;
    @(posedge clk); #1;
    check("end reset ready", 64'(ready_o), 64'd0);
    check("end reset result", result_o, 64'd0);
    start_i = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
